rastreador_extremos: RTL and testbench

Sample-stream extremum tracker. It sits directly upstream of the 8-bit cascaded magnitude comparator and consumes that comparator's results. It accepts unsigned samples through a valid/ready handshake and drives the comparator operands. From the comparator's equal/greater/less outputs it maintains the running maximum and minimum over a window of WINDOW samples, then signals window completion.

---
 rtl/rastreador_extremos.sv | 140 ++++++++++++++
 tb/tb_rastreador_extremos.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/rastreador_extremos.sv
// Running max/min tracker over a window of samples, driving an external
// magnitude comparator and consuming its equal/greater/less results.
module rastreador_extremos #(
  parameter int WIDTH  = 8,
  parameter int WINDOW = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             limpiar_i,
  input  logic [WIDTH-1:0] dato_i,
  input  logic             valido_i,
  output logic             listo_o,
  output logic [WIDTH-1:0] cmp_a_o,
  output logic [WIDTH-1:0] cmp_b_o,
  input  logic             igual_i,
  input  logic             mayor_i,
  input  logic             menor_i,
  output logic [WIDTH-1:0] maximo_o,
  output logic [WIDTH-1:0] minimo_o,
  output logic [7:0]       cuenta_o,
  output logic             fin_o
);

  typedef enum logic [1:0] {
    VACIO,
    ESPERA,
    CMP_MAX,
    CMP_MIN
  } estado_t;

  localparam logic [7:0] LP_WINDOW = 8'(WINDOW);

  estado_t          r_estado;
  estado_t          w_sig;
  logic [WIDTH-1:0] r_muestra;
  logic [WIDTH-1:0] r_maximo;
  logic [WIDTH-1:0] r_minimo;
  logic [7:0]       r_cuenta;
  logic             r_fin;

  logic [WIDTH-1:0] w_muestra;
  logic [WIDTH-1:0] w_maximo;
  logic [WIDTH-1:0] w_minimo;
  logic [7:0]       w_cuenta;
  logic [7:0]       w_cuenta_inc;
  logic             w_fin;
  logic             w_acepta;
  logic             w_sube;
  logic             w_baja;

  assign listo_o = ((r_estado == VACIO) || (r_estado == ESPERA))
                   & ~limpiar_i;
  assign w_acepta     = valido_i & listo_o;
  assign w_cuenta_inc = r_cuenta + 8'd1;

  // An inconsistent comparator result (equal plus greater/less) never updates.
  assign w_sube = mayor_i & ~igual_i;
  assign w_baja = menor_i & ~igual_i;

  assign cmp_a_o  = r_muestra;
  assign cmp_b_o  = (r_estado == CMP_MIN) ? r_minimo : r_maximo;
  assign maximo_o = r_maximo;
  assign minimo_o = r_minimo;
  assign cuenta_o = r_cuenta;
  assign fin_o    = r_fin;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_estado <= VACIO;
    end else begin
      r_estado <= w_sig;
    end
  end

  always_comb begin
    w_sig     = r_estado;
    w_muestra = r_muestra;
    w_maximo  = r_maximo;
    w_minimo  = r_minimo;
    w_cuenta  = r_cuenta;
    w_fin     = 1'b0;
    if (limpiar_i) begin
      w_sig     = VACIO;
      w_muestra = '0;
      w_maximo  = '0;
      w_minimo  = '0;
      w_cuenta  = '0;
    end else begin
      unique case (r_estado)
        VACIO: begin
          if (w_acepta) begin
            w_muestra = dato_i;
            w_maximo  = dato_i;
            w_minimo  = dato_i;
            w_cuenta  = 8'd1;
            w_sig     = ESPERA;
          end
        end
        ESPERA: begin
          if (w_acepta) begin
            w_muestra = dato_i;
            w_sig     = CMP_MAX;
          end
        end
        CMP_MAX: begin
          if (w_sube) w_maximo = r_muestra;
          w_sig = CMP_MIN;
        end
        CMP_MIN: begin
          if (w_baja) w_minimo = r_muestra;
          w_cuenta = w_cuenta_inc;
          if (w_cuenta_inc == LP_WINDOW) begin
            w_fin = 1'b1;
            w_sig = VACIO;
          end else begin
            w_sig = ESPERA;
          end
        end
        default: w_sig = VACIO;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_muestra <= '0;
      r_maximo  <= '0;
      r_minimo  <= '0;
      r_cuenta  <= '0;
      r_fin     <= 1'b0;
    end else begin
      r_muestra <= w_muestra;
      r_maximo  <= w_maximo;
      r_minimo  <= w_minimo;
      r_cuenta  <= w_cuenta;
      r_fin     <= w_fin;
    end
  end

endmodule

// File: tb/tb_rastreador_extremos.sv
// Directed bench: two trackers (window 4 and 2) sharing stimulus, each
// paired with a behavioural unsigned magnitude comparator.
module tb_rastreador_extremos;

  logic       clk;
  logic       reset;
  logic       limpiar;
  logic [7:0] dato;
  logic       valido;

  logic       listo4, fin4;
  logic [7:0] a4, b4, max4, min4, cta4;
  logic       igual4, mayor4, menor4;

  logic       listo2, fin2;
  logic [7:0] a2, b2, max2, min2, cta2;
  logic       igual2, mayor2, menor2;

  int pasadas = 0;
  int total   = 0;
  int cyc     = 0;

  assign igual4 = (a4 == b4);
  assign mayor4 = (a4 > b4);
  assign menor4 = (a4 < b4);
  assign igual2 = (a2 == b2);
  assign mayor2 = (a2 > b2);
  assign menor2 = (a2 < b2);

  rastreador_extremos #(.WIDTH(8), .WINDOW(4)) u_dut4 (
    .clk(clk), .reset(reset), .limpiar_i(limpiar),
    .dato_i(dato), .valido_i(valido), .listo_o(listo4),
    .cmp_a_o(a4), .cmp_b_o(b4),
    .igual_i(igual4), .mayor_i(mayor4), .menor_i(menor4),
    .maximo_o(max4), .minimo_o(min4), .cuenta_o(cta4), .fin_o(fin4)
  );

  rastreador_extremos #(.WIDTH(8), .WINDOW(2)) u_dut2 (
    .clk(clk), .reset(reset), .limpiar_i(limpiar),
    .dato_i(dato), .valido_i(valido), .listo_o(listo2),
    .cmp_a_o(a2), .cmp_b_o(b2),
    .igual_i(igual2), .mayor_i(mayor2), .menor_i(menor2),
    .maximo_o(max2), .minimo_o(min2), .cuenta_o(cta2), .fin_o(fin2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic chequear(input string tag, input logic [31:0] obs,
                          input logic [31:0] exp);
    total++;
    if (obs === exp) pasadas++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  task automatic enviar(input bit sel2, input logic [7:0] d,
                        output int t);
    int n;
    n = 0;
    @(negedge clk);
    dato   = d;
    valido = 1'b1;
    while (!(sel2 ? listo2 : listo4) && n < 30) begin
      @(negedge clk);
      n++;
    end
    if (n >= 30) chequear("timeout_listo", 32'(n), 32'd0);
    t = cyc;
    @(posedge clk);
  endtask

  task automatic esperar_fin(input bit sel2, output int t);
    int n;
    n = 0;
    while (!(sel2 ? fin2 : fin4) && n < 30) begin
      @(negedge clk);
      n++;
    end
    if (n >= 30) chequear("timeout_fin", 32'(n), 32'd0);
    t = cyc;
  endtask

  int t0, t1, t2, t3, tf;

  initial begin
    reset   = 1'b1;
    limpiar = 1'b0;
    dato    = 8'h00;
    valido  = 1'b0;
    #2;
    chequear("rst_max", 32'(max4), 32'h00);
    chequear("rst_min", 32'(min4), 32'h00);
    chequear("rst_cta", 32'(cta4), 32'h00);
    chequear("rst_fin", 32'(fin4), 32'h0);
    chequear("rst_listo", 32'(listo4), 32'h1);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;

    // back-to-back window of 4
    enviar(1'b0, 8'h50, t0);
    enviar(1'b0, 8'h20, t1);
    enviar(1'b0, 8'h90, t2);
    enviar(1'b0, 8'h20, t3);
    @(negedge clk);
    valido = 1'b0;
    esperar_fin(1'b0, tf);
    chequear("acc1_cyc", 32'(t1 - t0), 32'd1);
    chequear("acc2_cyc", 32'(t2 - t0), 32'd4);
    chequear("acc3_cyc", 32'(t3 - t0), 32'd7);
    chequear("fin_cyc", 32'(tf - t0), 32'd10);
    chequear("b2b_max", 32'(max4), 32'h90);
    chequear("b2b_min", 32'(min4), 32'h20);
    chequear("b2b_cta", 32'(cta4), 32'd4);
    @(negedge clk);
    chequear("fin_1cyc", 32'(fin4), 32'h0);
    chequear("hold_max", 32'(max4), 32'h90);

    // unsigned extremes
    enviar(1'b0, 8'h80, t0);
    enviar(1'b0, 8'hFF, t1);
    enviar(1'b0, 8'h00, t2);
    enviar(1'b0, 8'h7F, t3);
    @(negedge clk);
    valido = 1'b0;
    esperar_fin(1'b0, tf);
    chequear("uns_max", 32'(max4), 32'hFF);
    chequear("uns_min", 32'(min4), 32'h00);
    chequear("uns_cta", 32'(cta4), 32'd4);

    // gapped valid
    enviar(1'b0, 8'h50, t0);
    @(negedge clk);
    valido = 1'b0;
    repeat (5) @(negedge clk);
    enviar(1'b0, 8'h20, t1);
    @(negedge clk);
    valido = 1'b0;
    repeat (5) @(negedge clk);
    chequear("gap_listo", 32'(listo4), 32'h1);
    chequear("gap_max", 32'(max4), 32'h50);
    chequear("gap_min", 32'(min4), 32'h20);
    chequear("gap_cta", 32'(cta4), 32'd2);
    enviar(1'b0, 8'h90, t2);
    @(negedge clk);
    valido = 1'b0;
    repeat (5) @(negedge clk);
    enviar(1'b0, 8'h20, t3);
    @(negedge clk);
    valido = 1'b0;
    esperar_fin(1'b0, tf);
    chequear("gap_fmax", 32'(max4), 32'h90);
    chequear("gap_fmin", 32'(min4), 32'h20);
    chequear("gap_fcta", 32'(cta4), 32'd4);
    @(negedge clk);

    // synchronous clear during CMP_MAX
    enviar(1'b0, 8'h10, t0);
    enviar(1'b0, 8'hF0, t1);
    @(negedge clk);
    valido  = 1'b0;
    limpiar = 1'b1;
    #1;
    chequear("clr_listo", 32'(listo4), 32'h0);
    chequear("clr_fin0", 32'(fin4), 32'h0);
    @(negedge clk);
    limpiar = 1'b0;
    #1;
    chequear("clr_max", 32'(max4), 32'h00);
    chequear("clr_min", 32'(min4), 32'h00);
    chequear("clr_cta", 32'(cta4), 32'h00);
    chequear("clr_a", 32'(a4), 32'h00);
    chequear("clr_fin", 32'(fin4), 32'h0);
    chequear("clr_listo1", 32'(listo4), 32'h1);
    @(negedge clk);
    chequear("clr_fin2", 32'(fin4), 32'h0);
    enviar(1'b0, 8'h33, t0);
    @(negedge clk);
    valido = 1'b0;
    chequear("post_max", 32'(max4), 32'h33);
    chequear("post_min", 32'(min4), 32'h33);
    chequear("post_cta", 32'(cta4), 32'd1);

    // asynchronous reset mid-stream
    enviar(1'b0, 8'h12, t0);
    enviar(1'b0, 8'h34, t1);
    #2;
    valido = 1'b0;
    reset  = 1'b1;
    #1;
    chequear("arst_max", 32'(max4), 32'h00);
    chequear("arst_min", 32'(min4), 32'h00);
    chequear("arst_cta", 32'(cta4), 32'h00);
    chequear("arst_fin", 32'(fin4), 32'h0);
    chequear("arst_listo", 32'(listo4), 32'h1);
    @(negedge clk);
    reset = 1'b0;

    // window of 2, next sample presented in the fin cycle
    enviar(1'b1, 8'h11, t0);
    enviar(1'b1, 8'h22, t1);
    @(negedge clk);
    dato   = 8'h44;
    valido = 1'b1;
    esperar_fin(1'b1, tf);
    chequear("w2_fin_cyc", 32'(tf - t0), 32'd4);
    chequear("w2_listo", 32'(listo2), 32'h1);
    chequear("w2_max", 32'(max2), 32'h22);
    chequear("w2_min", 32'(min2), 32'h11);
    chequear("w2_cta", 32'(cta2), 32'd2);
    @(negedge clk);
    valido = 1'b0;
    chequear("w2n_cta", 32'(cta2), 32'd1);
    chequear("w2n_max", 32'(max2), 32'h44);
    chequear("w2n_min", 32'(min2), 32'h44);
    chequear("w2n_fin", 32'(fin2), 32'h0);

    $display("%0d/%0d checks passed", pasadas, total);
    $finish;
  end

endmodule
